display_timing_ctrl: RTL and testbench
======================================

DISPLAY_TIMING_CTRL -- requirements
Module: display_timing_ctrl

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: H_ACTIVE 640 visible pixels/line; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  level request to run display timing.
REQ-005 swap_req  in  1  writer has filled back buffer; held high until swap_ack.
REQ-006 ResetAddr  out  1  one-cycle pulse, clears downstream read-address counter.
REQ-007 IncAddr  out  1  high on each active pixel; advances downstream read-address counter.
REQ-008 buf_sel  out  1  front buffer being read: 0 = Buffer 0, 1 = Buffer 1.
REQ-009 swap_ack  out  1  one-cycle pulse, swap accepted.
REQ-010 hsync, vsync  out  1 each  active-low sync strobes.
REQ-011 active  out  1  visible-pixel flag, aligned with IncAddr.
REQ-012 frame_done  out  1  one-cycle pulse on last pixel clock of each frame.

Function
REQ-013 Counters: h_cnt 0..H_TOTAL-1, H_TOTAL = sum of H params; v_cnt 0..V_TOTAL-1, V_TOTAL = sum of V params.
REQ-014 Counter stepping: h_cnt increments every RUN/STOPPING cycle; h_cnt wraps to 0 at H_TOTAL-1, incrementing v_cnt; v_cnt wraps to 0 at V_TOTAL-1.
REQ-015 Counter widths SHALL be the minimum to hold H_TOTAL-1 / V_TOTAL-1; no overflow beyond wrap points.
REQ-016 All outputs registered: value in cycle k+1 decoded from (h_cnt, v_cnt) in cycle k; one-cycle latency.
REQ-017 active = IncAddr = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE); exactly H_ACTIVE*V_ACTIVE IncAddr cycles per frame (307200 at defaults, fits 20-bit address).
REQ-018 hsync low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-019 vsync low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, over whole lines.
REQ-020 ResetAddr and frame_done pulse when (h_cnt, v_cnt) = (H_TOTAL-1, V_TOTAL-1); ResetAddr also pulses on the cycle after IDLE->RUN.
REQ-021 FSM states: IDLE, RUN, STOPPING.
REQ-022 IDLE: counters held at 0; IncAddr/active/pulses low; hsync/vsync high. Exits to RUN when enable=1.
REQ-023 RUN: enable=0 -> STOPPING; frame continues.
REQ-024 STOPPING: enable=1 -> RUN. Otherwise at frame end -> IDLE; no partial frames are emitted.
REQ-025 Buffer swap: swap_req sampled on frame-end cycle (REQ-020), including a request first raised on that cycle. If high, buf_sel toggles and swap_ack pulses, both visible with frame_done.
REQ-026 Swap rules: at most one swap per frame; a swap_req low on frame end is ignored for that frame.
REQ-027 swap_ack is never asserted outside a frame-end cycle.

Reset
REQ-028 On resetn low, state SHALL immediately and asynchronously be: state=IDLE, h_cnt=v_cnt=0, buf_sel=0, IncAddr=active=ResetAddr=swap_ack=frame_done=0, hsync=vsync=1.
REQ-029 Reset mid-frame: abandon the frame with no frame_done or swap_ack. After release, run restarts at (0,0) with a ResetAddr pulse if enable=1.

Structure
REQ-030 display_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL functions, and the FSM state enum.
REQ-031 One sub-module disp_hv_counter (h/v counters and wrap flags); FSM, decode, and swap logic in the top level.

Verification (bench params H 4/1/2/1, H_TOTAL=8; V 3/1/1/1, V_TOTAL=6; frame=48 cycles)
REQ-032 Reset, then enable=1 held -> ResetAddr at cycle 1. Per frame: 12 IncAddr cycles in 3 bursts of 4; hsync low 2 cycles/line; vsync low 8 cycles; frame_done every 48 cycles.
REQ-033 swap_req raised mid-frame 0 -> buf_sel 0->1 and swap_ack together with first frame_done. swap_req dropped after ack -> no toggle at next frame end.
REQ-034 swap_req raised exactly on frame-end cycle -> accepted in that cycle (buf_sel toggles, swap_ack=1).
REQ-035 Stop/resume: enable drops at cycle 20 -> frame completes, IDLE from cycle 48, outputs quiescent. enable back at cycle 30 instead -> no interruption, continuous frames.
REQ-036 resetn asserted at cycle 25 with buf_sel=1 -> outputs immediately return to reset values without waiting for a clock edge, buf_sel=0, no frame_done. Release with enable=1 -> fresh frame with ResetAddr.

Source files
------------

// File: rtl/display_pkg.sv
// Shared timing defaults, derived totals, FSM states and the registered output bundle
// for the display timing controller.
package display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_e;

    typedef struct packed {
        logic reset_addr;
        logic inc_addr;
        logic buf_sel;
        logic swap_ack;
        logic hsync;
        logic vsync;
        logic active;
        logic frame_done;
    } disp_out_t;

    // Quiescent output pattern: sync strobes are active-low, so idle means high.
    localparam disp_out_t OUT_IDLE = '{
        reset_addr: 1'b0, inc_addr: 1'b0, buf_sel: 1'b0, swap_ack: 1'b0,
        hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_done: 1'b0
    };

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/disp_hv_counter.sv
// Horizontal/vertical position counters with wrap flags; advance only while step is high.
module disp_hv_counter
    import display_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int HW      = cnt_width(H_TOTAL),
    parameter int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          step,
    input  logic          clr,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_last,
    output logic          v_last
);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    assign h_last = (h_cnt_q == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == VW'(V_TOTAL - 1));
    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;

    always_comb begin
        // NOTE: hold-value defaults first so no path through this block infers a latch.
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clr) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (step) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

endmodule

// File: rtl/display_timing_ctrl.sv
// Display timing generator with run/stop FSM and frame-synchronous double-buffer swap.
// All outputs are registered one cycle behind the (h_cnt, v_cnt) position they decode.
module display_timing_ctrl
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic swap_req,
    output logic ResetAddr,
    output logic IncAddr,
    output logic buf_sel,
    output logic swap_ack,
    output logic hsync,
    output logic vsync,
    output logic active,
    output logic frame_done
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    state_e        state_q, state_d;
    disp_out_t     out_q, out_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last, v_last;
    logic          running, frame_end;
    logic [31:0]   h_ext, v_ext;

    assign running   = (state_q != ST_IDLE);
    assign frame_end = running && h_last && v_last;
    assign h_ext     = 32'(h_cnt);
    assign v_ext     = 32'(v_cnt);

    disp_hv_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_hv_counter (
        .clock  (clock),
        .resetn (resetn),
        .step   (running),
        .clr    (!running),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_last (h_last),
        .v_last (v_last)
    );

    always_comb begin
        state_d       = state_q;
        out_d         = OUT_IDLE;
        out_d.buf_sel = out_q.buf_sel;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d          = ST_RUN;
                    out_d.reset_addr = 1'b1;
                end
            end
            // Dropping enable on the frame-end cycle itself must not start another frame.
            ST_RUN: begin
                if (!enable) state_d = frame_end ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (enable)         state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (running) begin
            out_d.active     = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
            out_d.inc_addr   = out_d.active;
            out_d.hsync      = !((h_ext >= 32'(H_ACTIVE + H_FP)) &&
                                 (h_ext <  32'(H_ACTIVE + H_FP + H_SYNC)));
            out_d.vsync      = !((v_ext >= 32'(V_ACTIVE + V_FP)) &&
                                 (v_ext <  32'(V_ACTIVE + V_FP + V_SYNC)));
            out_d.frame_done = frame_end;
            out_d.reset_addr = frame_end;
            out_d.swap_ack   = frame_end && swap_req;
            out_d.buf_sel    = out_q.buf_sel ^ out_d.swap_ack;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign ResetAddr  = out_q.reset_addr;
    assign IncAddr    = out_q.inc_addr;
    assign buf_sel    = out_q.buf_sel;
    assign swap_ack   = out_q.swap_ack;
    assign hsync      = out_q.hsync;
    assign vsync      = out_q.vsync;
    assign active     = out_q.active;
    assign frame_done = out_q.frame_done;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Scoreboard bench: a frame-position reference model queues expected outputs each edge,
// a negedge monitor pops and compares; directed scenarios plus a randomized phase.
module tb_display_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic reset_addr;
        logic inc_addr;
        logic buf_sel;
        logic swap_ack;
        logic hsync;
        logic vsync;
        logic active;
        logic frame_done;
    } obs_t;

    localparam obs_t RST_OBS = '{
        reset_addr: 1'b0, inc_addr: 1'b0, buf_sel: 1'b0, swap_ack: 1'b0,
        hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_done: 1'b0
    };

    logic clock, resetn, enable, swap_req;
    logic ResetAddr, IncAddr, buf_sel, swap_ack, hsync, vsync, active, frame_done;

    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];

    bit   m_running = 1'b0;
    int   m_pos     = 0;
    bit   m_buf     = 1'b0;

    bit   in_frame = 1'b0;
    int   f_cyc = 0, f_inc = 0, f_hs = 0, f_vs = 0;

    display_timing_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .swap_req   (swap_req),
        .ResetAddr  (ResetAddr),
        .IncAddr    (IncAddr),
        .buf_sel    (buf_sel),
        .swap_ack   (swap_ack),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s.reset_addr = ResetAddr;
        s.inc_addr   = IncAddr;
        s.buf_sel    = buf_sel;
        s.swap_ack   = swap_ack;
        s.hsync      = hsync;
        s.vsync      = vsync;
        s.active     = active;
        s.frame_done = frame_done;
        return s;
    endfunction

    // Reference model: a frame is FRAME positions; each position maps to (pos % HT, pos / HT).
    always @(posedge clock) begin
        obs_t e;
        int   h, v;
        e = RST_OBS;
        if (!resetn) begin
            m_running = 1'b0;
            m_pos     = 0;
            m_buf     = 1'b0;
        end else if (!m_running) begin
            if (enable) begin
                e.reset_addr = 1'b1;
                m_running    = 1'b1;
                m_pos        = 0;
            end
        end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            e.active   = (h < HA) && (v < VA);
            e.inc_addr = e.active;
            e.hsync    = !(h >= HA + HF && h < HA + HF + HS);
            e.vsync    = !(v >= VA + VF && v < VA + VF + VS);
            if (m_pos == FRAME - 1) begin
                e.frame_done = 1'b1;
                e.reset_addr = 1'b1;
                if (swap_req) begin
                    m_buf      = !m_buf;
                    e.swap_ack = 1'b1;
                end
                if (!enable) m_running = 1'b0;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        e.buf_sel = m_buf;
        exp_q.push_back(e);
    end

    // Monitor: per-cycle scoreboard compare plus per-frame aggregate counts.
    always @(negedge clock) begin
        obs_t a, e;
        a = sample();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", 32'(a), 32'(e));
        end
        if (a.swap_ack) check("ack_on_frame_end", 32'(a.frame_done), 32'(1));
        if (!resetn) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && !(a.reset_addr && !a.frame_done)) begin
                f_cyc++;
                f_inc += 32'(a.inc_addr);
                f_hs  += 32'(!a.hsync);
                f_vs  += 32'(!a.vsync);
            end
            if (a.frame_done && in_frame) begin
                check("frame_cycles", 32'(f_cyc), 32'(FRAME));
                check("frame_inc_addr", 32'(f_inc), 32'(HA * VA));
                check("frame_hsync_low", 32'(f_hs), 32'(HS * VT));
                check("frame_vsync_low", 32'(f_vs), 32'(VS * HT));
            end
            if (a.reset_addr) begin
                in_frame = 1'b1;
                f_cyc = 0; f_inc = 0; f_hs = 0; f_vs = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic assert_reset();
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_values", 32'(sample()), 32'(RST_OBS));
    endtask

    task automatic wait_frame_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (frame_done) begin
                cycles = i;
                return;
            end
        end
        check("frame_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_swap_ack();
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (swap_ack) return;
        end
        check("swap_ack_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int n;
        int pulses;
        resetn   = 1'b1;
        enable   = 1'b0;
        swap_req = 1'b0;
        #1;
        assert_reset();
        tick(3);

        // Start-up: ResetAddr the cycle after leaving IDLE.
        resetn = 1'b1;
        enable = 1'b1;
        tick(1);
        check("start_reset_addr", 32'(ResetAddr), 32'(1));
        check("start_no_inc", 32'(IncAddr), 32'(0));

        // Swap requested mid-frame 0 is granted with the first frame_done.
        tick(10);
        swap_req = 1'b1;
        wait_swap_ack();
        check("swap1_frame_done", 32'(frame_done), 32'(1));
        check("swap1_buf_sel", 32'(buf_sel), 32'(1));
        swap_req = 1'b0;
        wait_frame_done(n);
        check("frame_period", 32'(n), 32'(FRAME));
        check("no_swap_after_drop", 32'(swap_ack), 32'(0));
        check("buf_sel_held", 32'(buf_sel), 32'(1));

        // Request raised exactly on the frame-end cycle.
        tick(FRAME - 1);
        swap_req = 1'b1;
        tick(1);
        check("late_req_frame_done", 32'(frame_done), 32'(1));
        check("late_req_ack", 32'(swap_ack), 32'(1));
        check("late_req_buf_sel", 32'(buf_sel), 32'(0));
        swap_req = 1'b0;

        // Stop at cycle 20: frame completes, then quiescent.
        tick(20);
        enable = 1'b0;
        wait_frame_done(n);
        check("stop_completes_frame", 32'(n), 32'(FRAME - 20));
        pulses = 0;
        repeat (10) begin
            tick(1);
            pulses += 32'(ResetAddr | frame_done | IncAddr | !hsync | !vsync);
        end
        check("idle_quiet", 32'(pulses), 32'(0));

        // Resume, drop at 20, re-enable at 30: continuous frames.
        enable = 1'b1;
        tick(1);
        check("resume_reset_addr", 32'(ResetAddr), 32'(1));
        tick(20);
        enable = 1'b0;
        tick(10);
        enable = 1'b1;
        wait_frame_done(n);
        check("stop_cancel_frame_end", 32'(n), 32'(FRAME - 30));
        wait_frame_done(n);
        check("stop_cancel_continuous", 32'(n), 32'(FRAME));

        // Randomized enable/swap traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if ($urandom_range(0, 29) == 0) enable = !enable;
            swap_req = ($urandom_range(0, 3) == 0);
        end

        // Reset mid-frame with buf_sel=1.
        swap_req = 1'b0;
        enable   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            swap_req = 1'b1;
            wait_swap_ack();
            swap_req = 1'b0;
            if (buf_sel) break;
        end
        check("pre_reset_buf_sel", 32'(buf_sel), 32'(1));
        tick(25);
        assert_reset();
        tick(2);
        check("reset_held_frame_done", 32'(frame_done), 32'(0));
        resetn = 1'b1;
        tick(1);
        check("post_reset_reset_addr", 32'(ResetAddr), 32'(1));
        wait_frame_done(n);
        check("post_reset_frame", 32'(n), 32'(FRAME));
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
